irq_source_ctrl: RTL and testbench

//   Requester side of the pipeline-control interrupt handshake. Synchronises and debounces the five

---
 rtl/irq_pkg.sv | 57 +++++
 rtl/irq_source_ctrl_if.sv | 22 ++
 rtl/btn_debounce.sv | 41 ++++
 rtl/irq_source_ctrl.sv | 128 ++++++++++++
 tb/tb_irq_source_ctrl.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt source controller.
// Pending bits: [7:5] div0/mem/decode errors, [4:0] up/down/left/right/centre buttons.
package irq_pkg;

    typedef enum logic [1:0] {StIdle, StReq, StServ, StClr} irq_state_e;

    localparam logic [31:0] CauseDiv0 = 32'd3;
    localparam logic [31:0] CauseMem  = 32'd4;
    localparam logic [31:0] CauseDec  = 32'd5;
    localparam logic [31:0] CauseBtn  = 32'd6;

    localparam logic [31:0] CodeUp     = 32'd1;
    localparam logic [31:0] CodeDown   = 32'd2;
    localparam logic [31:0] CodeLeft   = 32'd3;
    localparam logic [31:0] CodeRight  = 32'd4;
    localparam logic [31:0] CodeCentre = 32'd5;

    localparam int unsigned PendDiv    = 7;
    localparam int unsigned PendMem    = 6;
    localparam int unsigned PendDec    = 5;
    localparam int unsigned PendUp     = 4;
    localparam int unsigned PendDown   = 3;
    localparam int unsigned PendLeft   = 2;
    localparam int unsigned PendRight  = 1;
    localparam int unsigned PendCentre = 0;

    // Priority runs from the top bit down, so the highest set index wins.
    function automatic logic [2:0] prio_sel(input logic [7:0] pend);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (pend[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    function automatic logic [31:0] cause_of(input logic [2:0] idx);
        case (idx)
            3'(PendDiv): return CauseDiv0;
            3'(PendMem): return CauseMem;
            3'(PendDec): return CauseDec;
            default:     return CauseBtn;
        endcase
    endfunction

    function automatic logic [31:0] code_of(input logic [2:0] idx);
        case (idx)
            3'(PendUp):     return CodeUp;
            3'(PendDown):   return CodeDown;
            3'(PendLeft):   return CodeLeft;
            3'(PendRight):  return CodeRight;
            3'(PendCentre): return CodeCentre;
            default:        return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/irq_source_ctrl_if.sv
// Request/acknowledge handshake between the interrupt source controller and the PCU.
// master is the requester side, slave is the pipeline controller side.
interface irq_source_ctrl_if;
    logic        irq_ack;
    logic        irq_done;
    logic        ovf_clr;
    logic        irq_req;
    logic [31:0] irq_cause;
    logic [31:0] irq_code;
    logic [7:0]  irq_pending;
    logic        irq_ovf;

    modport master (
        input  irq_ack, irq_done, ovf_clr,
        output irq_req, irq_cause, irq_code, irq_pending, irq_ovf
    );

    modport slave (
        output irq_ack, irq_done, ovf_clr,
        input  irq_req, irq_cause, irq_code, irq_pending, irq_ovf
    );
endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus consecutive-cycle debounce for one button.
// rise pulses on the same edge the debounced level goes 0->1.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    logic             s1_q, s2_q, deb_q;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;

    // cnt_q counts cycles already seen differing; this edge is the final one.
    assign accept = (s2_q != deb_q) && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));
    assign rise   = accept & s2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            deb_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q <= btn;
            s2_q <= s1_q;
            if (s2_q == deb_q) begin
                cnt_q <= '0;
            end else if (accept) begin
                deb_q <= s2_q;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_source_ctrl.sv
// Latches button and CPU error events as pending bits and presents them to the PCU
// one prioritised request at a time, holding each until handler completion.
module irq_source_ctrl
    import irq_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                butu,
    input  logic                butd,
    input  logic                butl,
    input  logic                butr,
    input  logic                butc,
    input  logic [3:0]          error,
    irq_source_ctrl_if.master   bus
);

    logic [4:0]  btn_raw, btn_rise;
    logic [3:0]  error_q;
    logic        err_new;
    logic [7:0]  ev, pend_q, pend_d;
    logic        ovf_q, ovf_d;
    irq_state_e  state_q;
    logic [2:0]  sel_q, win;
    logic        req_q, done_q;
    logic [31:0] cause_q, code_q;

    assign btn_raw = {butu, butd, butl, butr, butc};

    for (genvar i = 0; i < 5; i++) begin : gen_deb
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_deb (
            .clk (clk),
            .rst (rst),
            .btn (btn_raw[i]),
            .rise(btn_rise[i])
        );
    end

    // A held error code raises a single event; codes above 3 never do.
    assign err_new = (error != error_q);

    always_comb begin
        ev          = '0;
        ev[4:0]     = btn_rise;
        ev[PendDiv] = err_new && (error == 4'd1);
        ev[PendMem] = err_new && (error == 4'd2);
        ev[PendDec] = err_new && (error == 4'd3);
    end

    // A new event for the source being cleared keeps its bit set.
    always_comb begin
        pend_d = pend_q;
        if (state_q == StClr) pend_d[sel_q] = 1'b0;
        pend_d = pend_d | ev;
    end

    always_comb begin
        ovf_d = ovf_q;
        if (|(ev & pend_q)) ovf_d = 1'b1;
        else if (bus.ovf_clr) ovf_d = 1'b0;
    end

    assign win = prio_sel(pend_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            error_q <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            error_q <= error;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            sel_q   <= '0;
            req_q   <= 1'b0;
            cause_q <= '0;
            code_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= bus.irq_done;
            unique case (state_q)
                StIdle: begin
                    if (|pend_q) begin
                        state_q <= StReq;
                        sel_q   <= win;
                        req_q   <= 1'b1;
                        cause_q <= cause_of(win);
                        code_q  <= code_of(win);
                    end
                end
                StReq: begin
                    if (bus.irq_ack) begin
                        state_q <= StServ;
                        req_q   <= 1'b0;
                    end
                end
                // Only a fresh rising edge counts, so a stale completion flag is ignored.
                StServ: begin
                    if (bus.irq_done && !done_q) state_q <= StClr;
                end
                StClr: begin
                    state_q <= StIdle;
                    cause_q <= '0;
                    code_q  <= '0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.irq_req     = req_q;
    assign bus.irq_cause   = cause_q;
    assign bus.irq_code    = code_q;
    assign bus.irq_pending = pend_q;
    assign bus.irq_ovf     = ovf_q;

endmodule

// File: tb/tb_irq_source_ctrl.sv
// Scoreboard bench: a sample-history reference model predicts requests and pending state,
// a monitor checks each request the DUT raises against the predicted queue.
module tb_irq_source_ctrl;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       butu = 1'b0, butd = 1'b0, butl = 1'b0, butr = 1'b0, butc = 1'b0;
    logic [3:0] error = 4'd0;

    irq_source_ctrl_if bus();

    irq_source_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .butu (butu),
        .butd (butd),
        .butl (butl),
        .butr (butr),
        .butc (butc),
        .error(error),
        .bus  (bus.master)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int cause_tab[8] = '{6, 6, 6, 6, 6, 5, 4, 3};
    int code_tab[8]  = '{5, 4, 3, 2, 1, 0, 0, 0};

    logic [D:0]  mhist [5];   // [0] newest raw sample
    logic [4:0]  mdeb;
    logic [3:0]  merr;
    logic [7:0]  mpend;
    logic        movf;
    logic        mdone;
    int          mphase;      // 0 idle, 1 requesting, 2 in handler, 3 clearing
    int          msel;
    logic [63:0] expq[$];

    initial begin
        forever begin
            logic [4:0] b_in;
            logic [7:0] ev;
            @(posedge clk);
            b_in = {butu, butd, butl, butr, butc};
            if (rst) begin
                for (int b = 0; b < 5; b++) mhist[b] = '0;
                mdeb = '0; merr = '0; mpend = '0; movf = 1'b0; mdone = 1'b0;
                mphase = 0; msel = 0;
            end else begin
                ev = '0;
                for (int b = 0; b < 5; b++) begin
                    logic [D-1:0] w;
                    w = mhist[b][D:1];
                    if (w == '1 && !mdeb[b]) begin
                        mdeb[b] = 1'b1;
                        ev[b]   = 1'b1;
                    end else if (w == '0 && mdeb[b]) begin
                        mdeb[b] = 1'b0;
                    end
                    mhist[b] = {mhist[b][D-1:0], b_in[b]};
                end
                if (error != merr && error >= 4'd1 && error <= 4'd3) ev[8 - int'(error)] = 1'b1;
                merr = error;
                if ((ev & mpend) != 0) movf = 1'b1;
                else if (bus.ovf_clr) movf = 1'b0;
                case (mphase)
                    0: if (mpend != 0) begin
                        for (int i = 7; i >= 0; i--) begin
                            if (mpend[i]) begin
                                msel = i;
                                break;
                            end
                        end
                        mphase = 1;
                        expq.push_back({32'(cause_tab[msel]), 32'(code_tab[msel])});
                    end
                    1: if (bus.irq_ack) mphase = 2;
                    2: if (bus.irq_done && !mdone) mphase = 3;
                    default: begin
                        mpend[msel] = 1'b0;
                        mphase = 0;
                    end
                endcase
                mpend = mpend | ev;
                mdone = bus.irq_done;
            end
        end
    end

    // ---------------- monitor ----------------
    logic prev_req = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            check("irq_req", 64'(bus.irq_req), 64'(mphase == 1));
            check("irq_pending", 64'(bus.irq_pending), 64'(mpend));
            check("irq_ovf", 64'(bus.irq_ovf), 64'(movf));
            if (mphase == 0)
                check("idle_cause_code", {bus.irq_cause, bus.irq_code}, 64'd0);
            if (bus.irq_req && !prev_req) begin
                if (expq.size() == 0) begin
                    check("unexpected_request", 64'(1), 64'(0));
                end else begin
                    logic [63:0] e;
                    e = expq.pop_front();
                    check("req_cause", 64'(bus.irq_cause), 64'(e[63:32]));
                    check("req_code", 64'(bus.irq_code), 64'(e[31:0]));
                end
            end
            prev_req = bus.irq_req;
        end
    end

    // ---------------- PCU emulation and stimulus ----------------
    logic acked     = 1'b0;
    logic hold_ack  = 1'b0;
    logic slow_done = 1'b0;
    logic rand_mode = 1'b0;
    int   ack_wait  = 0;
    int   done_wait = 0;
    int   done_hold = 0;
    int   btn_hold[5] = '{0, 0, 0, 0, 0};
    int   err_hold  = 0;

    task automatic tick();
        logic [4:0] bv;
        @(negedge clk);
        bus.irq_ack = 1'b0;
        if (rst) begin
            acked = 1'b0;
            bus.irq_done = 1'b0;
            ack_wait = 0;
        end else if (!acked) begin
            if (bus.irq_req && !hold_ack) begin
                if (ack_wait == 0) begin
                    bus.irq_ack = 1'b1;
                    acked = 1'b1;
                    done_wait = slow_done ? 40 : int'($urandom_range(2, 7));
                end else begin
                    ack_wait--;
                end
            end
        end else if (done_wait > 0) begin
            done_wait--;
            if (done_wait == 1) bus.irq_done = 1'b0;
            if (done_wait == 0) begin
                bus.irq_done = 1'b1;
                done_hold = int'($urandom_range(1, 3));
            end
        end else begin
            done_hold--;
            if (done_hold <= 0) begin
                if ($urandom_range(0, 3) != 0) bus.irq_done = 1'b0;
                acked = 1'b0;
                ack_wait = int'($urandom_range(0, 4));
            end
        end
        if (rand_mode) begin
            bv = {butu, butd, butl, butr, butc};
            for (int b = 0; b < 5; b++) begin
                if (btn_hold[b] == 0) begin
                    bv[b] = 1'($urandom_range(0, 1));
                    btn_hold[b] = int'($urandom_range(1, 8));
                end else begin
                    btn_hold[b]--;
                end
            end
            {butu, butd, butl, butr, butc} = bv;
            if (err_hold == 0) begin
                error = 4'($urandom_range(0, 7));
                err_hold = int'($urandom_range(1, 10));
            end else begin
                err_hold--;
            end
            bus.ovf_clr = ($urandom_range(0, 15) == 0);
            rst = ($urandom_range(0, 399) == 0);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL timeout: simulation exceeded cycle budget");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        bus.irq_ack = 1'b0;
        bus.irq_done = 1'b0;
        bus.ovf_clr = 1'b0;
        ticks(3);
        rst = 1'b0;

        // Held button: accepted after debounce, served with cause 6 / code 1.
        butu = 1'b1; ticks(40); butu = 1'b0; ticks(20);

        // Glitch of 3 cycles rejected, 4 cycles accepted.
        butl = 1'b1; ticks(3); butl = 1'b0; ticks(12);
        butl = 1'b1; ticks(4); butl = 1'b0; ticks(30);

        // Error held with a stale completion flag already high.
        bus.irq_done = 1'b1;
        error = 4'd1; ticks(20); error = 4'd0; ticks(30);

        // Button and memory error pending on the same edge.
        butr = 1'b1; ticks(5); error = 4'd2; ticks(10);
        butr = 1'b0; error = 4'd0; ticks(40);

        // Re-press during service sets overflow and a second request.
        slow_done = 1'b1;
        butc = 1'b1; ticks(8); butc = 1'b0; ticks(8);
        butc = 1'b1; ticks(8); butc = 1'b0; ticks(8);
        butc = 1'b1; ticks(8); butc = 1'b0;
        ticks(80);
        slow_done = 1'b0;
        ticks(60);
        bus.ovf_clr = 1'b1; tick(); bus.ovf_clr = 1'b0; ticks(5);

        // Randomised traffic with occasional resets.
        rand_mode = 1'b1;
        ticks(4000);
        rand_mode = 1'b0;
        rst = 1'b0; bus.ovf_clr = 1'b0;
        {butu, butd, butl, butr, butc} = '0; error = 4'd0;
        ticks(120);

        // Reset while a request is outstanding with several bits pending.
        hold_ack = 1'b1;
        error = 4'd1; butu = 1'b1; butd = 1'b1;
        begin
            int guard;
            guard = 0;
            while (!(bus.irq_req && $countones(bus.irq_pending) >= 3) && guard < 60) begin
                tick();
                guard++;
            end
            check("reach_req_with_3_pending", 64'(guard < 60), 64'(1));
        end
        rst = 1'b1; tick(); rst = 1'b0;
        hold_ack = 1'b0;
        error = 4'd0; butu = 1'b0; butd = 1'b0;
        ticks(60);

        check("scoreboard_drained", 64'(expq.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
